morse_msg_sequencer: RTL and testbench
======================================

// Module: morse_msg_sequencer
// PURPOSE
//  Plays a stored message (A-Z letters plus word spaces) through the single-letter Morse engine.
//  Fetches one symbol at a time from an internal message RAM and launches the engine with a start/busy handshake.
//  Inserts the standard inter-letter gap (3 units) and inter-word gap (7 units).
//  Sits between the board switches/keys and the letter engine, and owns the engine's start input.
// PARAMETERS
//  UNIT_CYCLES  12_500_000  clocks per Morse unit (0.25 s at 50 MHz); must be >= 2
//  MSG_DEPTH    16          message RAM entries
//  ADDR_W       4           clog2(MSG_DEPTH)
// PORTS
//  CLOCK_50     in   1         system clock, all logic on rising edge
//  reset        in   1         asynchronous, active-high; clears state and all outputs
//  start        in   1         one-cycle pulse; begin playback (debounced upstream)
//  stop         in   1         level; abort playback
//  wr_en        in   1         message RAM write strobe
//  wr_addr      in   ADDR_W    message RAM write address
//  wr_data      in   5         symbol: 0-25 = A-Z, 31 = word space, 26-30 = skip
//  msg_len      in   ADDR_W+1  number of symbols to play (0..MSG_DEPTH), latched on start
//  letter_code  out  5         letter to engine, held stable from letter_start until engine idle
//  letter_start out  1         one-cycle launch pulse to engine
//  letter_busy  in   1         engine busy while sending a letter
//  busy         out  1         high from accepted start until return to IDLE
//  done         out  1         one-cycle pulse on normal completion
//  cur_index    out  ADDR_W    index of symbol being played
// BEHAVIOUR
//  Reset: state IDLE; letter_code=0, letter_start=0, busy=0, done=0, cur_index=0; RAM contents undefined.
//  RAM: 1 write port and 1 registered read port; wr_en is ignored while busy=1.
//  FSM: IDLE -> FETCH -> DISPATCH -> {LAUNCH -> WAIT_ENG -> GAP | GAP | next} -> ... -> IDLE
//   IDLE: start with msg_len!=0 latches len, sets idx=0, goes to FETCH.
//    start with msg_len==0 pulses done next cycle and stays IDLE; start while busy is ignored.
//   FETCH: drive read address idx; data is valid one cycle later in DISPATCH.
//   DISPATCH: 0-25 -> LAUNCH; 31 -> GAP(7); 26-30 -> skip symbol (no output, no gap).
//   LAUNCH: letter_start=1 for one cycle with letter_code valid, then WAIT_ENG.
//   WAIT_ENG: ignore letter_busy for the first cycle, then wait for letter_busy==0.
//    Afterwards: last symbol -> done, else GAP(3).
//   GAP(n): exactly n*UNIT_CYCLES clocks, then idx+1 and FETCH.
//  A space directly after a letter replaces that letter's 3-unit gap: total 7, not 10.
//  A space as the last symbol still plays its 7-unit gap before done.
//  Completion: done=1 for one cycle in the cycle after the last symbol ends; busy falls in the same cycle.
//  stop=1 in any non-IDLE state returns to IDLE next cycle: no done, no further letter_start.
//   An in-flight engine letter is not recalled.
//  start and stop in the same IDLE cycle: stop wins, nothing starts.
//  Async reset mid-playback: immediate IDLE; letter_start deasserts asynchronously.
//  cur_index updates on entry to FETCH; it holds the last value in IDLE until the next start.
//  Unit timer: counts down from UNIT_CYCLES-1; a unit counter counts gap units; both clear on entering GAP.
// CONFIGURATION
//  MORSE_LOOP_EN defined: adds input port `loop` (1 bit).
//   If loop=1 when the last symbol ends: pulse done, play GAP(7), wrap idx to 0, replay.
//   This repeats until stop; msg_len is not re-latched.
//  MORSE_LOOP_EN undefined: no `loop` port; playback is always one-shot.
// STRUCTURE
//  morse_pkg: SYM_SPACE=5'd31, LETTER_MAX=5'd25, GAP_LETTER=3, GAP_WORD=7, state encoding localparams.
//  Sub-module morse_unit_timer: prescaler + unit countdown; inputs clear/load_units, output gap_done pulse.
//  RAM is inferred inline in the sequencer.
// TESTING (UNIT_CYCLES=4 in simulation; engine model stays busy for 5 cycles after letter_start)
//  1. Write "S","O","S" (18,14,18), msg_len=3, start:
//     -> 3 letter_start pulses with codes 18,14,18; 12-cycle gaps between engine idle and next FETCH; one done; busy=0 after.
//  2. Message {0,31,1} (A, space, B):
//     -> idle-to-next-FETCH gap after A is 28 cycles, not 40; letter_start for codes 0 and 1 only.
//  3. msg_len=0, start -> done=1 on the next cycle; busy stays 0; no letter_start.
//  4. stop=1 during the GAP after letter 1 of 3 -> IDLE next cycle; no done; no further letter_start.
//     Repeat with reset=1 mid-WAIT_ENG -> all outputs 0 immediately.
//  5. Message with symbol 27 between two letters -> skipped; one 12-cycle gap; wr_en while busy leaves RAM unchanged.
//  6. MORSE_LOOP_EN defined, loop=1, "E" (4), msg_len=1:
//     -> letter_start every 5+1+28+fetch cycles; done every pass; stop ends playback.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared symbol codes, gap lengths and FSM state encoding for the Morse message sequencer.
package morse_pkg;

    localparam logic [4:0] SYM_SPACE  = 5'd31;
    localparam logic [4:0] LETTER_MAX = 5'd25;
    localparam logic [2:0] GAP_LETTER = 3'd3;
    localparam logic [2:0] GAP_WORD   = 3'd7;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_DISPATCH = 3'd2;
    localparam logic [2:0] ST_LAUNCH   = 3'd3;
    localparam logic [2:0] ST_WAIT     = 3'd4;
    localparam logic [2:0] ST_GAP      = 3'd5;

    function automatic logic is_letter(input logic [4:0] sym);
        return sym <= LETTER_MAX;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Gap timer: a prescaler of UNIT_CYCLES clocks per unit plus a unit counter.
// gap_done_o is high during the last clock of a gap of load_units_i units.
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 12_500_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic [2:0] load_units_i,
    input  logic       run_i,
    output logic       gap_done_o
);

    localparam int            PW     = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [PW-1:0] RELOAD = PW'(UNIT_CYCLES - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    unit_q, unit_d;
    logic [2:0]    units_q, units_d;

    always_comb begin
        presc_d = presc_q;
        unit_d  = unit_q;
        units_d = units_q;
        if (clear_i) begin
            presc_d = RELOAD;
            unit_d  = 3'd0;
            units_d = load_units_i;
        end else if (run_i) begin
            if (presc_q == '0) begin
                presc_d = RELOAD;
                unit_d  = unit_q + 3'd1;
            end else begin
                presc_d = presc_q - 1'b1;
            end
        end
    end

    assign gap_done_o = run_i && (presc_q == '0) && (unit_q == units_q - 3'd1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
            unit_q  <= 3'd0;
            units_q <= 3'd0;
        end else begin
            presc_q <= presc_d;
            unit_q  <= unit_d;
            units_q <= units_d;
        end
    end

endmodule

// File: rtl/morse_msg_sequencer.sv
// Plays a stored A-Z/space message through the single-letter Morse engine with standard gaps.
// Define MORSE_LOOP_EN to add the `loop` input for continuous replay.
module morse_msg_sequencer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 12_500_000,
    parameter int MSG_DEPTH   = 16,
    parameter int ADDR_W      = 4
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [4:0]        wr_data,
    input  logic [ADDR_W:0]   msg_len,
`ifdef MORSE_LOOP_EN
    input  logic              loop,
`endif
    output logic [4:0]        letter_code,
    output logic              letter_start,
    input  logic              letter_busy,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_index
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(MSG_DEPTH);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   nxt_q, nxt_d;
    logic [4:0]        code_q, code_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic              first_q, first_d;
    logic              lstart_q, lstart_d;
    logic              done_q, done_d;

    logic              t_clr, gap_done, loop_w, end_sym;
    logic [2:0]        t_units;
    logic [ADDR_W:0]   end_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic [4:0]        rd_q;
    logic [4:0]        mem_q [MSG_DEPTH];

`ifdef MORSE_LOOP_EN
    assign loop_w = loop;
`else
    assign loop_w = 1'b0;
`endif

    assign busy         = (state_q != ST_IDLE);
    assign letter_code  = code_q;
    assign letter_start = lstart_q;
    assign done         = done_q;
    assign cur_index    = cur_q;

    // While the engine is busy, peek at the following symbol so a word space can absorb the letter gap.
    assign rd_addr = (state_q == ST_WAIT) ? idx_q[ADDR_W-1:0] + 1'b1 : idx_q[ADDR_W-1:0];

    always_ff @(posedge CLOCK_50) begin
        if (wr_en && !busy)
            mem_q[wr_addr] <= wr_data;
        rd_q <= mem_q[rd_addr];
    end

    morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
        .clk_i       (CLOCK_50),
        .rst_i       (reset),
        .clear_i     (t_clr),
        .load_units_i(t_units),
        .run_i       (state_q == ST_GAP),
        .gap_done_o  (gap_done)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        nxt_d    = nxt_q;
        code_d   = code_q;
        cur_d    = cur_q;
        first_d  = first_q;
        lstart_d = 1'b0;
        done_d   = 1'b0;
        t_clr    = 1'b0;
        t_units  = GAP_LETTER;
        end_sym  = 1'b0;
        end_idx  = idx_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (msg_len != '0) begin
                        len_d   = (msg_len > DEPTH_W) ? DEPTH_W : msg_len;
                        idx_d   = '0;
                        cur_d   = '0;
                        state_d = ST_FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_FETCH: state_d = ST_DISPATCH;
            ST_DISPATCH: begin
                if (is_letter(rd_q)) begin
                    code_d   = rd_q;
                    lstart_d = 1'b1;
                    state_d  = ST_LAUNCH;
                end else if (rd_q == SYM_SPACE) begin
                    state_d = ST_GAP;
                    t_clr   = 1'b1;
                    t_units = GAP_WORD;
                    nxt_d   = end_idx;
                end else begin
                    end_sym = 1'b1;
                end
            end
            ST_LAUNCH: begin
                first_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                first_d = 1'b0;
                if (!first_q && !letter_busy) begin
                    if (end_idx >= len_q) begin
                        end_sym = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        t_clr   = 1'b1;
                        if (rd_q == SYM_SPACE) begin
                            t_units = GAP_WORD;
                            nxt_d   = idx_q + 2'd2;
                        end else begin
                            nxt_d = end_idx;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    end_sym = 1'b1;
                    end_idx = nxt_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A symbol has fully played: advance, finish, or (loop mode) finish and replay after a word gap.
        if (end_sym) begin
            if (end_idx >= len_q) begin
                done_d = 1'b1;
                if (loop_w) begin
                    state_d = ST_GAP;
                    t_clr   = 1'b1;
                    t_units = GAP_WORD;
                    nxt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end else begin
                state_d = ST_FETCH;
                idx_d   = end_idx;
                cur_d   = end_idx[ADDR_W-1:0];
            end
        end

        if (stop && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            lstart_d = 1'b0;
            done_d   = 1'b0;
            t_clr    = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            nxt_q    <= '0;
            code_q   <= 5'd0;
            cur_q    <= '0;
            first_q  <= 1'b0;
            lstart_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            nxt_q    <= nxt_d;
            code_q   <= code_d;
            cur_q    <= cur_d;
            first_q  <= first_d;
            lstart_q <= lstart_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_morse_msg_sequencer.sv
// Self-checking bench: per-cycle comparison against a duration-based playback schedule.
module tb_morse_msg_sequencer;

    localparam int U        = 4;
    localparam int DEPTH    = 16;
    localparam int AW       = 4;
    localparam int BUSY_LEN = 5;
    localparam int MAXW     = 1024;

    logic          CLOCK_50 = 1'b0;
    logic          reset    = 1'b1;
    logic          start    = 1'b0;
    logic          stop     = 1'b0;
    logic          wr_en    = 1'b0;
    logic [AW-1:0] wr_addr  = '0;
    logic [4:0]    wr_data  = '0;
    logic [AW:0]   msg_len  = '0;
`ifdef MORSE_LOOP_EN
    logic          loop     = 1'b0;
`endif
    logic [4:0]    letter_code;
    logic          letter_start, letter_busy, busy, done;
    logic [AW-1:0] cur_index;

    morse_msg_sequencer #(.UNIT_CYCLES(U), .MSG_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .msg_len     (msg_len),
`ifdef MORSE_LOOP_EN
        .loop        (loop),
`endif
        .letter_code (letter_code),
        .letter_start(letter_start),
        .letter_busy (letter_busy),
        .busy        (busy),
        .done        (done),
        .cur_index   (cur_index)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Engine stand-in: busy for BUSY_LEN cycles after each launch pulse.
    int eng_cnt = 0;
    always @(posedge CLOCK_50)
        if (letter_start) eng_cnt <= BUSY_LEN;
        else if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
    assign letter_busy = (eng_cnt != 0);

    int nchk = 0, nerr = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, got, exp);
        end
    endtask

    // Expected outputs per cycle; cycle 1 is the first cycle after start is sampled.
    bit exp_ls[MAXW];
    bit exp_done[MAXW];
    bit exp_busy[MAXW];
    int exp_code[MAXW];
    int exp_cur[MAXW];
    int ls_code[MAXW];
    int fetch_at[MAXW];
    int msg[DEPTH];
    int prev_cur = 0, prev_code = 0;
    int end_t;

    task automatic build_model(input int len, input bit lp, input int stop_c);
        int t, i, s, after, cur, code;
        for (int c = 0; c < MAXW; c++) begin
            exp_ls[c] = 0; exp_done[c] = 0; exp_busy[c] = 0; ls_code[c] = 0; fetch_at[c] = -1;
        end
        end_t = 1;
        if (len == 0) begin
            exp_done[1] = 1;
        end else begin
            t = 1; i = 0;
            while (t < MAXW - 40) begin
                fetch_at[t] = i;
                s = msg[i];
                if (s <= 25) begin
                    exp_ls[t + 2] = 1;
                    ls_code[t + 2] = s;
                    after = t + BUSY_LEN + 4;
                    if (i + 1 < len && msg[i + 1] == 31) begin t = after + 7 * U; i += 2; end
                    else if (i + 1 < len) begin t = after + 3 * U; i++; end
                    else begin t = after; i++; end
                end else if (s == 31) begin
                    t = t + 2 + 7 * U; i++;
                end else begin
                    t = t + 2; i++;
                end
                if (i >= len) begin
                    exp_done[t] = 1;
                    if (!lp) break;
                    t += 7 * U;
                    i = 0;
                end
            end
            end_t = t;
            for (int c = 1; c < end_t && c < MAXW; c++) exp_busy[c] = 1;
        end
        if (stop_c >= 0)
            for (int c = stop_c + 1; c < MAXW; c++) begin
                exp_ls[c] = 0; exp_done[c] = 0; exp_busy[c] = 0; fetch_at[c] = -1;
            end
        cur = prev_cur; code = prev_code;
        for (int c = 1; c < MAXW; c++) begin
            if (fetch_at[c] >= 0) cur = fetch_at[c];
            if (exp_ls[c]) code = ls_code[c];
            exp_cur[c] = cur;
            exp_code[c] = code;
        end
    endtask

    always @(negedge CLOCK_50) if (chk_en) begin
        chk("letter_start", int'(letter_start), int'(exp_ls[cyc]));
        chk("done",         int'(done),         int'(exp_done[cyc]));
        chk("busy",         int'(busy),         int'(exp_busy[cyc]));
        chk("letter_code",  int'(letter_code),  exp_code[cyc]);
        chk("cur_index",    int'(cur_index),    exp_cur[cyc]);
    end

    task automatic load(input int len);
        for (int i = 0; i < len; i++) begin
            @(posedge CLOCK_50); #1;
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = 5'(msg[i]);
        end
        @(posedge CLOCK_50); #1 wr_en = 1'b0;
        repeat (8) @(posedge CLOCK_50);
    endtask

    task automatic run(input int len, input bit lp, input int stop_c, input int wr_c);
        int run_len;
        build_model(len, lp, stop_c);
        run_len = (stop_c >= 0) ? stop_c + 4 : end_t + 3;
`ifdef MORSE_LOOP_EN
        loop = lp;
`endif
        @(posedge CLOCK_50); #1;
        msg_len = (AW + 1)'(len);
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        cyc = 1;
        chk_en = 1'b1;
        while (cyc < run_len) begin
            stop  = (cyc == stop_c);
            wr_en = (cyc == wr_c);
            wr_addr = AW'(2);
            wr_data = 5'd0;
            @(posedge CLOCK_50); #1;
            cyc++;
        end
        chk_en = 1'b0;
        stop = 1'b0;
        wr_en = 1'b0;
`ifdef MORSE_LOOP_EN
        loop = 1'b0;
`endif
        prev_cur = exp_cur[run_len - 1];
        prev_code = exp_code[run_len - 1];
        repeat (8) @(posedge CLOCK_50);
    endtask

    initial begin
        int len, stop_c, r;
        repeat (2) @(posedge CLOCK_50);
        #1;
        chk("rst_letter_start", int'(letter_start), 0);
        chk("rst_letter_code",  int'(letter_code), 0);
        chk("rst_busy",         int'(busy), 0);
        chk("rst_done",         int'(done), 0);
        chk("rst_cur_index",    int'(cur_index), 0);
        reset = 1'b0;
        repeat (2) @(posedge CLOCK_50);

        // SOS: launches at 3, 24, 45; done at 52.
        msg[0] = 18; msg[1] = 14; msg[2] = 18;
        load(3);
        build_model(3, 0, -1);
        chk("model_sos_ls1", int'(exp_ls[3]), 1);
        chk("model_sos_ls2", int'(exp_ls[24]), 1);
        chk("model_sos_code3", ls_code[45], 18);
        chk("model_sos_done", end_t, 52);
        run(3, 0, -1, -1);

        // A, space, B: 28-cycle gap after A; B launches at 40, done at 47.
        msg[0] = 0; msg[1] = 31; msg[2] = 1;
        load(3);
        build_model(3, 0, -1);
        chk("model_ab_ls", int'(exp_ls[40]), 1);
        chk("model_ab_done", end_t, 47);
        run(3, 0, -1, -1);

        // Empty message: done next cycle, never busy.
        build_model(0, 0, -1);
        chk("model_empty_done", int'(exp_done[1]), 1);
        run(0, 0, -1, -1);

        // Stop in the gap after the first SOS letter.
        msg[0] = 18; msg[1] = 14; msg[2] = 18;
        load(3);
        run(3, 0, 12, -1);

        // Async reset while waiting on the engine.
        @(posedge CLOCK_50); #1;
        msg_len = 5'd3; start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        repeat (4) @(posedge CLOCK_50);
        #2 reset = 1'b1;
        #1;
        chk("arst_letter_start", int'(letter_start), 0);
        chk("arst_letter_code",  int'(letter_code), 0);
        chk("arst_busy",         int'(busy), 0);
        chk("arst_done",         int'(done), 0);
        chk("arst_cur_index",    int'(cur_index), 0);
        @(posedge CLOCK_50); #1 reset = 1'b0;
        prev_cur = 0; prev_code = 0;
        repeat (8) @(posedge CLOCK_50);

        // Skip symbol between letters; write attempt while busy must be ignored.
        msg[0] = 7; msg[1] = 27; msg[2] = 8;
        load(3);
        run(3, 0, -1, 2);

        for (int k = 0; k < 10; k++) begin
            len = $urandom_range(0, 10);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 9);
                if (r < 6) msg[i] = $urandom_range(0, 25);
                else if (r < 8) msg[i] = 31;
                else msg[i] = $urandom_range(26, 30);
            end
            load(len);
            build_model(len, 0, -1);
            stop_c = -1;
            if (len > 0 && $urandom_range(0, 3) == 0) stop_c = $urandom_range(2, end_t - 1);
            run(len, 0, stop_c, -1);
        end

`ifdef MORSE_LOOP_EN
        msg[0] = 4;
        load(1);
        build_model(1, 1, -1);
        chk("model_loop_ls2", int'(exp_ls[40]), 1);
        chk("model_loop_done2", int'(exp_done[47]), 1);
        run(1, 1, 120, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
